// File: rtl/rob_multi.sv
// Reorder buffer: compacted multi-lane allocation, multi-port completion,
// in-order multi-lane commit and partial squash behind a surviving branch tag.
module rob_multi #(
  parameter int DEPTH     = 16,
  parameter int ALLOC_W   = 2,
  parameter int COMMIT_W  = 2,
  parameter int CPL_PORTS = 2,
  parameter int PREG_BITS = 6,
  parameter int TAG_BITS  = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_W-1:0]            alloc_valid,
  input  logic [ALLOC_W*5-1:0]          alloc_ard,
  input  logic [ALLOC_W*PREG_BITS-1:0]  alloc_prd,
  input  logic [ALLOC_W*PREG_BITS-1:0]  alloc_prd_old,
  input  logic [ALLOC_W-1:0]            alloc_reg_write,
  output logic                          alloc_ready,
  output logic [ALLOC_W*TAG_BITS-1:0]   alloc_tag,
  input  logic [CPL_PORTS-1:0]          cpl_valid,
  input  logic [CPL_PORTS*TAG_BITS-1:0] cpl_tag,
  input  logic                          flush_en,
  input  logic [TAG_BITS-1:0]           flush_tag,
  input  logic                          commit_stall,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W*5-1:0]         commit_ard,
  output logic [COMMIT_W*PREG_BITS-1:0] commit_prd,
  output logic [COMMIT_W*PREG_BITS-1:0] commit_prd_old,
  output logic [COMMIT_W-1:0]           commit_reg_write,
  output logic [TAG_BITS-1:0]           head_tag,
  output logic [TAG_BITS:0]             count,
  output logic                          full,
  output logic                          empty
);
  localparam int CNT_W = TAG_BITS + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALLOC_C = CNT_W'(ALLOC_W);

  genvar gi;

  logic [TAG_BITS-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     n_alloc, n_commit;
  logic [TAG_BITS-1:0]  alloc_off;
  logic [TAG_BITS-1:0]  lane_tag [ALLOC_W];
  logic [TAG_BITS-1:0]  flush_age;
  logic                 flush_live;
  logic                 commit_run;
  logic [COMMIT_W-1:0]  lane_ok;
  logic [DEPTH-1:0]     ent_valid, ent_ready, ent_rw;
  logic [4:0]           ent_ard     [DEPTH];
  logic [PREG_BITS-1:0] ent_prd     [DEPTH];
  logic [PREG_BITS-1:0] ent_prd_old [DEPTH];

  // Liveness is purely age-based: age = (tag - head) mod DEPTH, live iff age < count.
  assign flush_age   = flush_tag - head_q;
  assign flush_live  = flush_en && ({1'b0, flush_age} < count_q);
  assign alloc_ready = ((DEPTH_C - count_q) >= ALLOC_C) && !flush_en;

  always_comb begin
    alloc_off = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      lane_tag[i] = tail_q + alloc_off;
      alloc_off   = alloc_off + TAG_BITS'(alloc_valid[i]);
    end
    n_alloc = alloc_ready ? CNT_W'(alloc_off) : '0;
  end

  for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
    assign alloc_tag[gi*TAG_BITS +: TAG_BITS] = lane_tag[gi];
  end

  // A flushing branch bounds commit: nothing younger than it may retire.
  for (gi = 0; gi < COMMIT_W; gi++) begin : g_commit
    logic [TAG_BITS-1:0] idx;
    assign idx = head_q + TAG_BITS'(gi);
    assign lane_ok[gi] = (CNT_W'(gi) < count_q) && ent_valid[idx] && ent_ready[idx]
                         && (!flush_live || (TAG_BITS'(gi) <= flush_age));
    assign commit_ard[gi*5 +: 5]                    = ent_ard[idx];
    assign commit_prd[gi*PREG_BITS +: PREG_BITS]     = ent_prd[idx];
    assign commit_prd_old[gi*PREG_BITS +: PREG_BITS] = ent_prd_old[idx];
    assign commit_reg_write[gi]                      = ent_rw[idx];
  end

  always_comb begin
    commit_run   = !commit_stall;
    commit_valid = '0;
    n_commit     = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_run      = commit_run && lane_ok[k];
      commit_valid[k] = commit_run;
      n_commit        = n_commit + CNT_W'(commit_run);
    end
  end

  always_comb begin
    head_d = head_q + n_commit[TAG_BITS-1:0];
    if (flush_live) begin
      tail_d  = flush_tag + TAG_BITS'(1);
      count_d = CNT_W'(flush_age) + CNT_W'(1) - n_commit;
    end else begin
      tail_d  = tail_q + n_alloc[TAG_BITS-1:0];
      count_d = count_q + n_alloc - n_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [TAG_BITS-1:0]  age;
    logic                 live, clr, cpl_hit, alloc_hit;
    logic                 valid_q, ready_q, rw_q, wr_rw;
    logic [4:0]           ard_q, wr_ard;
    logic [PREG_BITS-1:0] prd_q, prd_old_q, wr_prd, wr_prd_old;

    assign age  = TAG_BITS'(gi) - head_q;
    assign live = {1'b0, age} < count_q;
    assign clr  = ({1'b0, age} < n_commit) || (flush_live && (age > flush_age));

    always_comb begin
      cpl_hit = 1'b0;
      for (int p = 0; p < CPL_PORTS; p++)
        if (cpl_valid[p] && (cpl_tag[p*TAG_BITS +: TAG_BITS] == TAG_BITS'(gi)))
          cpl_hit = 1'b1;
    end

    always_comb begin
      alloc_hit  = 1'b0;
      wr_ard     = '0;
      wr_prd     = '0;
      wr_prd_old = '0;
      wr_rw      = 1'b0;
      for (int i = 0; i < ALLOC_W; i++) begin
        if (alloc_ready && alloc_valid[i] && (lane_tag[i] == TAG_BITS'(gi))) begin
          alloc_hit  = 1'b1;
          wr_ard     = alloc_ard[i*5 +: 5];
          wr_prd     = alloc_prd[i*PREG_BITS +: PREG_BITS];
          wr_prd_old = alloc_prd_old[i*PREG_BITS +: PREG_BITS];
          wr_rw      = alloc_reg_write[i];
        end
      end
    end

    // Allocation only targets non-live slots, so it never collides with clr.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        valid_q <= 1'b0;
        ready_q <= 1'b0;
      end else if (alloc_hit) begin
        valid_q <= 1'b1;
        ready_q <= 1'b0;
      end else if (cpl_hit && live) begin
        ready_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (alloc_hit) begin
        ard_q     <= wr_ard;
        prd_q     <= wr_prd;
        prd_old_q <= wr_prd_old;
        rw_q      <= wr_rw;
      end
    end

    assign ent_valid[gi]   = valid_q;
    assign ent_ready[gi]   = ready_q;
    assign ent_rw[gi]      = rw_q;
    assign ent_ard[gi]     = ard_q;
    assign ent_prd[gi]     = prd_q;
    assign ent_prd_old[gi] = prd_old_q;
  end

  assign head_tag = head_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a queue-of-live-entries model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rob_multi;
  localparam int D = 16;
  localparam int TB = 4;
  localparam int PB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    alloc_valid;
  logic [9:0]    alloc_ard;
  logic [11:0]   alloc_prd, alloc_prd_old;
  logic [1:0]    alloc_reg_write;
  logic          alloc_ready;
  logic [7:0]    alloc_tag;
  logic [1:0]    cpl_valid;
  logic [7:0]    cpl_tag;
  logic          flush_en;
  logic [3:0]    flush_tag;
  logic          commit_stall;
  logic [1:0]    commit_valid;
  logic [9:0]    commit_ard;
  logic [11:0]   commit_prd, commit_prd_old;
  logic [1:0]    commit_reg_write;
  logic [3:0]    head_tag;
  logic [4:0]    count;
  logic          full, empty;

  rob_multi #(.DEPTH(D), .ALLOC_W(2), .COMMIT_W(2), .CPL_PORTS(2), .PREG_BITS(PB)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ard(alloc_ard), .alloc_prd(alloc_prd),
    .alloc_prd_old(alloc_prd_old), .alloc_reg_write(alloc_reg_write),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .flush_en(flush_en), .flush_tag(flush_tag), .commit_stall(commit_stall),
    .commit_valid(commit_valid), .commit_ard(commit_ard), .commit_prd(commit_prd),
    .commit_prd_old(commit_prd_old), .commit_reg_write(commit_reg_write),
    .head_tag(head_tag), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seq = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         tag;
    logic [4:0] ard;
    logic [5:0] prd;
    logic [5:0] old;
    logic       rw;
    logic       rdy;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;
  int   m_tail = 0;
  int   fidx, ncom, off;
  logic exp_rdy;
  ent_t e;

  // Model: the ROB is the ordered list of live entries, oldest first.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      exp_rdy = ((D - mq.size()) >= 2) && !flush_en;
      chk("alloc_ready", alloc_ready, exp_rdy);
      chk("count", count, mq.size());
      chk("head_tag", head_tag, m_head);
      chk("full", full, mq.size() == D);
      chk("empty", empty, mq.size() == 0);

      fidx = -1;
      if (flush_en)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].tag == int'(flush_tag)) fidx = i;

      ncom = 0;
      if (!commit_stall)
        while (ncom < 2 && ncom < mq.size() && mq[ncom].rdy && (fidx < 0 || ncom <= fidx))
          ncom++;
      chk("commit_valid", commit_valid, (1 << ncom) - 1);
      for (int k = 0; k < ncom; k++) begin
        chk("commit_ard", commit_ard[k*5 +: 5], mq[k].ard);
        chk("commit_prd", commit_prd[k*PB +: PB], mq[k].prd);
        chk("commit_prd_old", commit_prd_old[k*PB +: PB], mq[k].old);
        chk("commit_reg_write", commit_reg_write[k], mq[k].rw);
      end

      off = 0;
      if (exp_rdy)
        for (int i = 0; i < 2; i++)
          if (alloc_valid[i]) begin
            chk("alloc_tag", alloc_tag[i*TB +: TB], (m_tail + off) % D);
            off++;
          end

      for (int p = 0; p < 2; p++)
        if (cpl_valid[p])
          for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == int'(cpl_tag[p*TB +: TB]) && (fidx < 0 || i <= fidx))
              mq[i].rdy = 1'b1;

      if (fidx >= 0) begin
        while (mq.size() > fidx + 1) void'(mq.pop_back());
        m_tail = (int'(flush_tag) + 1) % D;
      end

      for (int k = 0; k < ncom; k++) begin
        e = mq.pop_front();
        $display("commit tag %0d ard %0d prd %0d", e.tag, e.ard, e.prd);
        m_head = (m_head + 1) % D;
      end

      if (exp_rdy)
        for (int i = 0; i < 2; i++)
          if (alloc_valid[i]) begin
            e.tag = m_tail;
            e.ard = alloc_ard[i*5 +: 5];
            e.prd = alloc_prd[i*PB +: PB];
            e.old = alloc_prd_old[i*PB +: PB];
            e.rw  = alloc_reg_write[i];
            e.rdy = 1'b0;
            mq.push_back(e);
            $display("alloc tag %0d lane %0d", m_tail, i);
            m_tail = (m_tail + 1) % D;
          end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [1:0] v);
    alloc_valid = v;
    for (int i = 0; i < 2; i++) begin
      alloc_ard[i*5 +: 5]      = 5'(seq);
      alloc_prd[i*PB +: PB]    = 6'(seq + 7);
      alloc_prd_old[i*PB +: PB] = 6'(seq * 3);
      alloc_reg_write[i]       = seq[0];
      seq++;
    end
  endtask

  task automatic do_alloc(input logic [1:0] v);
    set_alloc(v);
    tick();
    alloc_valid = 2'b00;
  endtask

  task automatic do_cpl(input logic [1:0] v, input int t0, input int t1);
    cpl_valid = v;
    cpl_tag   = {4'(t1), 4'(t0)};
    tick();
    cpl_valid = 2'b00;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_valid = '0; alloc_ard = '0; alloc_prd = '0; alloc_prd_old = '0; alloc_reg_write = '0;
    cpl_valid = '0; cpl_tag = '0; flush_en = 1'b0; flush_tag = '0; commit_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_head_tag", head_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);

    // Fill: 8 x 2 lanes -> tags 0..15, then a dropped 9th request.
    set_alloc(2'b11);
    #1 chk("first_lane1_tag", alloc_tag[7:4], 1);
    tick();
    for (int c = 1; c < 8; c++) do_alloc(2'b11);
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_alloc_ready", alloc_ready, 0);
    do_alloc(2'b11);
    chk("dropped_count", count, 16);
    for (int c = 0; c < 8; c++) do_cpl(2'b11, 2*c, 2*c + 1);
    wait_empty();

    // Sparse lanes: 11, 01, 10 -> tags 0,1 / 2 / 3 on lane 1.
    do_alloc(2'b11);
    do_alloc(2'b01);
    set_alloc(2'b10);
    #1 chk("lane1_tag3", alloc_tag[7:4], 3);
    tick();
    alloc_valid = 2'b00;
    chk("sparse_count", count, 4);

    // Out-of-order completion: 1 then 0.
    cpl_valid = 2'b01; cpl_tag = 8'h01;
    tick();
    cpl_tag = 8'h00;
    #1 chk("blocked_commit", commit_valid, 2'b00);
    tick();
    cpl_valid = 2'b00;
    #1 chk("commit_pair", commit_valid, 2'b11);
    tick();
    chk("after_pair_commit", commit_valid, 2'b00);
    chk("after_pair_count", count, 2);
    do_cpl(2'b11, 2, 3);
    wait_empty();

    // Move head to 12, then 10 live entries 12..5.
    for (int c = 0; c < 4; c++) do_alloc(2'b11);
    for (int c = 0; c < 4; c++) do_cpl(2'b11, 4 + 2*c, 5 + 2*c);
    wait_empty();
    chk("head_at_12", head_tag, 12);
    for (int c = 0; c < 5; c++) do_alloc(2'b11);
    chk("ten_live", count, 10);
    flush_en = 1'b1; flush_tag = 4'd14;
    tick();
    flush_en = 1'b0;
    chk("flush_count", count, 3);
    do_cpl(2'b01, 2, 0);
    chk("stale_cpl_count", count, 3);
    chk("stale_cpl_no_commit", commit_valid, 2'b00);

    // Flush whose branch itself commits in the same cycle.
    do_cpl(2'b11, 12, 13);
    flush_en = 1'b1; flush_tag = 4'd13;
    #1 chk("flush_cycle_commit", commit_valid, 2'b11);
    tick();
    flush_en = 1'b0;
    chk("flush_commit_count", count, 0);
    chk("flush_commit_head", head_tag, 14);

    // Flush and allocate together; flush of a non-live tag.
    do_alloc(2'b11);
    flush_en = 1'b1; flush_tag = 4'd14;
    set_alloc(2'b11);
    #1 chk("flush_blocks_alloc", alloc_ready, 0);
    tick();
    alloc_valid = 2'b00;
    flush_tag = 4'd5;
    #1 chk("flush_alloc_count", count, 1);
    tick();
    flush_en = 1'b0;
    chk("dead_flush_count", count, 1);
    set_alloc(2'b01);
    #1 chk("tail_after_flush", alloc_tag[3:0], 15);
    tick();
    alloc_valid = 2'b00;

    // Commit stall.
    do_cpl(2'b11, 14, 15);
    commit_stall = 1'b1;
    #1 chk("stall_commit", commit_valid, 2'b00);
    tick();
    chk("stall_count", count, 2);
    commit_stall = 1'b0;
    #1 chk("unstall_commit", commit_valid, 2'b11);
    tick();

    // Reset mid-stream with a committable head.
    do_alloc(2'b11);
    do_cpl(2'b01, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_head", head_tag, 0);
    do_alloc(2'b11);
    do_cpl(2'b11, 0, 1);
    wait_empty();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
